// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - parametrised single-port data memory with clear-on-reset and request handshake
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   req_valid/ready    request handshake; a request is taken when both are high
//   WriteEnable        1 = store, 0 = load (sampled on an accepted request)
//   addr_in            byte address; must be word aligned and within DEPTH words
//   data_in, byte_en   store data and per-byte lane mask
//   data_out, rd_valid registered load data and its one-cycle valid pulse
//   addr_err           one-cycle pulse after an accepted misaligned/out-of-range request
//   init_busy          high while the post-reset clear sequence runs
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                WriteEnable,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                addr_err,
  output logic                init_busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOP_LSB = OFF_W + IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic               misaligned;
  logic               out_of_range;
  logic               req_err;
  logic               accept;
  logic               do_store;
  logic               do_load;

  // Address decode: word index sits just above the byte-offset bits;
  // anything set above the index means the word does not exist.
  assign idx          = addr_in[TOP_LSB-1:OFF_W];
  assign off          = addr_in[OFF_W-1:0];
  assign misaligned   = (off != '0);
  assign out_of_range = ((addr_in >> TOP_LSB) != '0);
  assign req_err      = misaligned || out_of_range;

  assign accept   = req_valid && req_ready;
  assign do_store = accept && WriteEnable && !req_err;
  assign do_load  = accept && !WriteEnable && !req_err;

  // State register and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // Next state and state-decoded outputs; req_ready depends on state only
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        if (clr_ptr == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Storage: clearing owns the array in INIT, so requests cannot race it.
  // While rst is held the pointer is pinned at 0, hence only word 0 is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
    end else if (state_q == ST_INIT) begin
      mem[clr_ptr] <= '0;
    end else if (do_store) begin
      for (int k = 0; k < BYTES; k++) begin
        if (byte_en[k]) begin
          mem[idx][8*k +: 8] <= data_in[8*k +: 8];
        end
      end
    end
  end

  // Response path: single-cycle load latency; errors leave data_out untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= do_load;
      addr_err <= accept && req_err;
      if (do_load) begin
        data_out <= mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard testbench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        WriteEnable;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic [1:0]  byte_en;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        addr_err;
  logic        init_busy;

  data_mem_ctrl #(.DATA_W(16), .DEPTH(16), .ADDR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .WriteEnable (WriteEnable),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .byte_en     (byte_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .addr_err    (addr_err),
    .init_busy   (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;   // 1 = load result, 2 = address error
    logic [15:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model [16];
  logic [15:0] last_rd;
  int          cyc = 0;
  int          nchecks = 0;
  int          nerrs = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: a due entry must see its response; any other response is spurious
  always @(negedge clk) begin
    if (!done) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        check("rd_valid", 32'(rd_valid), 32'(e.kind == 1));
        check("addr_err", 32'(addr_err), 32'(e.kind == 2));
        check("data_out", 32'(data_out), 32'(e.data));
      end else if (rd_valid || addr_err) begin
        check("spurious_resp", 32'({rd_valid, addr_err}), 32'(0));
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    last_rd = 16'h0000;
  endtask

  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be);
    exp_t e;
    logic err;
    @(posedge clk);
    #1;
    req_valid   = 1'b1;
    WriteEnable = we;
    addr_in     = a;
    data_in     = d;
    byte_en     = be;
    err = a[0] || (a[15:5] != 11'd0);
    if (err) begin
      e.due = cyc + 1; e.kind = 2; e.data = last_rd;
      sbq.push_back(e);
    end else if (we) begin
      if (be[0]) model[a[4:1]][7:0]  = d[7:0];
      if (be[1]) model[a[4:1]][15:8] = d[15:8];
    end else begin
      last_rd = model[a[4:1]];
      e.due = cyc + 1; e.kind = 1; e.data = last_rd;
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the edge on which rst was last sampled high
  task automatic wait_init();
    int cnt;
    cnt = 0;
    while (init_busy && cnt < 100) begin
      check("init_ready_low", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      cnt++;
    end
    check("init_len", 32'(cnt), 32'(16));
    check("run_busy", 32'(init_busy), 32'(0));
    check("run_ready", 32'(req_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    rst = 1'b1; req_valid = 1'b0; WriteEnable = 1'b0;
    addr_in = '0; data_in = '0; byte_en = '0;
    clear_model();

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(init_busy), 32'(1));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_dout", 32'(data_out), 32'(0));
    check("rst_rdv", 32'(rd_valid), 32'(0));
    check("rst_err", 32'(addr_err), 32'(0));
    rst = 1'b0;

    // A store held through the whole INIT window must be ignored
    req_valid = 1'b1; WriteEnable = 1'b1; addr_in = 16'h0002;
    data_in = 16'h7777; byte_en = 2'b11;
    wait_init();
    req_valid = 1'b0;

    // Every word reads back cleared, back to back
    for (int i = 0; i < 16; i++) do_req(1'b0, 16'(2 * i), 16'h0, 2'b00);

    // Full-word store then load
    do_req(1'b1, 16'h0000, 16'h000F, 2'b11);
    do_req(1'b0, 16'h0000, 16'h0, 2'b00);
    do_req(1'b1, 16'h001E, 16'hBEEF, 2'b11);
    do_req(1'b0, 16'h001E, 16'h0, 2'b00);
    idle();

    // Byte lanes
    do_req(1'b1, 16'h0004, 16'h1234, 2'b11);
    do_req(1'b1, 16'h0004, 16'hABCD, 2'b01);
    do_req(1'b0, 16'h0004, 16'h0, 2'b00);
    do_req(1'b1, 16'h0004, 16'hABCD, 2'b10);
    do_req(1'b0, 16'h0004, 16'h0, 2'b00);
    do_req(1'b1, 16'h0004, 16'h0000, 2'b00);
    do_req(1'b0, 16'h0004, 16'h0, 2'b00);
    idle();

    // Address errors
    do_req(1'b0, 16'h0003, 16'h0, 2'b00);
    do_req(1'b1, 16'h0020, 16'hFFFF, 2'b11);
    do_req(1'b1, 16'h8000, 16'hFFFF, 2'b11);
    do_req(1'b0, 16'h0000, 16'h0, 2'b00);
    do_req(1'b0, 16'h0021, 16'h0, 2'b00);
    idle();
    idle();

    // Alternating store/load every cycle
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      do_req(1'b1, 16'(2 * i), d, 2'b11);
      do_req(1'b0, 16'(2 * i), 16'h0, 2'b00);
    end
    idle();

    // Reset landing on the accept edge of a load
    do_req(1'b1, 16'h0008, 16'h5555, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid = 1'b1; WriteEnable = 1'b0; addr_in = 16'h0008;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("midrst_rdv", 32'(rd_valid), 32'(0));
    check("midrst_err", 32'(addr_err), 32'(0));
    check("midrst_dout", 32'(data_out), 32'(0));
    check("midrst_busy", 32'(init_busy), 32'(1));
    rst = 1'b0;
    clear_model();
    wait_init();
    do_req(1'b0, 16'h0008, 16'h0, 2'b00);
    do_req(1'b0, 16'h001E, 16'h0, 2'b00);
    idle();
    repeat (3) idle();

    check("sb_drain", 32'(sbq.size()), 32'(0));
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised single-port data memory for the MEM stage of the pipelined MIPS datapath. It is the successor to the fixed 16-bit DM. It adds:
- generic data width and depth
- byte-lane write enables
- a valid/ready request handshake
- a registered read with a valid strobe
- address-error detection
- a hardware clear sequence after reset that zeroes every word before the first request is accepted.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8 and at least 16.
DEPTH, 16, number of words; must be a power of 2 and at least 2.
ADDR_W, 16, byte-address width of addr_in.
(derived) BYTES = DATA_W/8; OFF_W = log2(BYTES); IDX_W = log2(DEPTH).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous active-high reset.
req_valid  input  1  request present this cycle.
req_ready  output  1  block can accept a request this cycle.
WriteEnable  input  1  1 = store, 0 = load; sampled only on an accepted request.
addr_in  input  ADDR_W  byte address.
data_in  input  DATA_W  store data.
byte_en  input  BYTES  per-byte store mask; bit k controls bits [8k+7:8k].
data_out  output  DATA_W  registered load data.
rd_valid  output  1  one-cycle pulse: data_out holds a new load result.
addr_err  output  1  one-cycle pulse: the previous accepted request was rejected.
init_busy  output  1  clear sequence in progress.

Behaviour:
- Reset: rst is synchronous and active-high, on the clk edge, and has priority over everything.
  - After the reset edge: state=INIT, clr_ptr=0, data_out=0, rd_valid=0, addr_err=0, init_busy=1, req_ready=0.
  - While rst is held, INIT writes only mem[0]=0; clr_ptr stays 0.
- FSM has 2 states:
  - INIT: each cycle writes mem[clr_ptr]=0 and increments clr_ptr. After the cycle that writes DEPTH-1, the next state is RUN. INIT therefore takes exactly DEPTH cycles after rst deasserts.
  - RUN: init_busy=0, req_ready=1. Stays in RUN until rst.
- req_ready is combinational from state only (1 in RUN, 0 in INIT). It must not depend on req_valid.
- Accept condition: req_valid && req_ready. Requests in INIT are ignored: no side effect, no response.
- Address decode: idx = addr_in[OFF_W+IDX_W-1:OFF_W].
  - Misaligned: addr_in[OFF_W-1:0] != 0.
  - Out of range: addr_in[ADDR_W-1:OFF_W+IDX_W] != 0.
  - Either condition makes the request an error.
- Accepted valid store: at that edge, write data_in bytes to mem[idx] for lanes with byte_en=1; other lanes are unchanged. byte_en=0 is legal and is a no-op write. A store produces no rd_valid.
- Accepted valid load: at that edge, data_out<=mem[idx] and rd_valid<=1. Latency is 1 cycle.
- Error request (load or store): memory is unchanged and data_out holds. addr_err<=1 and rd_valid<=0 at the next edge.
- rd_valid and addr_err are 0 in every cycle not immediately following an accepted request of that kind. data_out holds its last load value indefinitely.
- Back-to-back requests are accepted every cycle in RUN; throughput is 1 per cycle.
  - Load in cycle N+1 from the word stored in cycle N returns the new data. The write commits at edge N, so no bypass is needed.
- Memory contents are held as a DEPTH x DATA_W register array. Reading beyond DEPTH is impossible by construction, because the range check gates the access.
- Reset mid-INIT restarts clearing from 0. Reset mid-RUN discards any in-flight response (rd_valid/addr_err forced 0) and re-clears all memory.

Test Plan:
1. Reset/INIT, defaults: rst=1 for 2 cycles, then 0 -> init_busy=1 and req_ready=0 for exactly 16 cycles, then init_busy=0 and req_ready=1. Loads of addresses 0x0000..0x001E (step 2) return 0x0000 with rd_valid=1 one cycle after each accept.
2. Full-word store/load: store addr 0x0000 data 0x000F byte_en=2'b11, then load 0x0000 the next cycle -> data_out=0x000F, rd_valid=1 one cycle after the load. Store 0x001E data 0xBEEF, load 0x001E -> 0xBEEF.
3. Byte lanes: mem[2]=0x1234 (addr 0x0004); store 0xABCD with byte_en=2'b01 -> read 0x12CD. Then store 0xABCD with byte_en=2'b10 -> read 0xABCD. Then byte_en=2'b00 store of 0x0000 -> read 0xABCD.
4. Address errors: load 0x0003 (misaligned) -> addr_err=1 for 1 cycle, rd_valid=0, data_out unchanged. Store 0x0020 (out of range) data 0xFFFF -> addr_err=1, and a later load of 0x0000 is unchanged.
5. Handshake/INIT blocking: assert req_valid with a store to 0x0002 during INIT -> no effect; the first load after INIT returns 0x0000. In RUN, alternate store/load every cycle across 16 addresses -> each load returns the value stored the prior cycle.
6. Reset mid-operation: write 0x5555 to 0x0008, issue a load, assert rst on the cycle of the accept -> rd_valid stays 0 and data_out=0. After 16 INIT cycles, load 0x0008 returns 0x0000.
